bus_master: RTL and testbench
=============================

Name: bus_master

Overview:
- Single-initiator bus controller: the requesting end of the device bus protocol (en/wr/addr/data/wt) that peripherals such as the timer answer on.
- Accepts one read/write command at a time from a client (CPU or DMA side) and drives the device-side select/write/address/data lines.
- Stretches the access while the device asserts wt, returns read data with a one-cycle ack, and aborts with an error if wt never deasserts.

Parameters:
- ADDR_WIDTH, 2, width of cpu_addr / dev_addr.
- TIMEOUT, 255, consecutive wt=1 access cycles before abort; 0 disables timeout; max 65535.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  command valid; sampled only in IDLE
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_WIDTH  device register address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  timeout flag, valid only with cpu_ack
- busy  out  1  1 in ACCESS or DONE
- dev_en  out  1  device select
- dev_wr  out  1  device write strobe
- dev_addr  out  ADDR_WIDTH  device address
- dev_data_out  out  32  data to device
- dev_data_in  in  32  data from device, combinational on dev_addr
- dev_wt  in  1  device wait request

Behaviour:
- All outputs registered.
- Reset values: state IDLE; dev_en=0, dev_wr=0, dev_addr=0, dev_data_out=0, cpu_rdata=0, cpu_ack=0, cpu_err=0, busy=0, wait counter=0.
- FSM IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - dev_en=0, dev_wr=0.
  - On an edge with cpu_req=1: latch cpu_we, cpu_addr, cpu_wdata into dev_wr, dev_addr, dev_data_out; set dev_en=1; clear wait counter; go to ACCESS.
- ACCESS:
  - dev_en=1; dev_wr/dev_addr/dev_data_out held stable for the whole state.
  - Edge with dev_wt=0 completes the transfer. The device commits writes on this same edge.
    - Read: cpu_rdata <= dev_data_in. Write: cpu_rdata <= 0.
    - cpu_ack <= 1, cpu_err <= 0, dev_en <= 0, dev_wr <= 0; go to DONE.
  - Edge with dev_wt=1: wait counter += 1.
    - If TIMEOUT != 0 and the incremented count equals TIMEOUT: abort with cpu_rdata <= 0, cpu_ack <= 1, cpu_err <= 1, dev_en <= 0, dev_wr <= 0; go to DONE.
    - Otherwise remain in ACCESS.
  - Wait counter is 16 bits and saturates at 65535 when TIMEOUT=0, so it never wraps.
- DONE:
  - cpu_ack=1 for exactly this cycle; cpu_req is ignored here.
  - Next edge: cpu_ack <= 0, cpu_err <= 0; go to IDLE. cpu_rdata holds until the next completion.
- Latency:
  - Zero-wait transfer: req sampled at edge E0; dev_en=1 in cycle E0..E1; cpu_ack=1 in cycle E1..E2.
  - Each dev_wt=1 cycle adds 1.
  - Minimum issue interval is 3 cycles.
- Client rules:
  - Command fields must be stable while cpu_req=1 in IDLE.
  - cpu_req still high in the IDLE cycle after ack starts a new transfer.
- Reset in any state: next edge returns to IDLE with reset values; dev_en drops; no ack or err is emitted for the killed transfer.
- dev_wt is ignored outside ACCESS.

Test Plan:
- Write, zero-wait: cpu_req=1, we=1, addr=1, wdata=0x0000C350, dev_wt=0.
  -> dev_en=dev_wr=1 for exactly 1 cycle with dev_addr=1 and dev_data_out=0x0000C350.
  -> cpu_ack=1 one cycle later, cpu_err=0, cpu_rdata=0.
- Read, 3 wait cycles: we=0, addr=0, dev_wt=1 for the first 3 ACCESS cycles, dev_data_in=0x00000003.
  -> dev_en high 4 cycles; cpu_ack 1 cycle after dev_en falls; cpu_rdata=0x00000003; err=0.
- Timeout, TIMEOUT=8, dev_wt stuck at 1.
  -> dev_en high exactly 8 cycles; cpu_ack=1 with cpu_err=1 and cpu_rdata=0; busy falls one cycle later.
- Back-to-back: cpu_req held high for two commands (write then read), dev_wt=0.
  -> Two ack pulses 3 cycles apart; second dev_en starts in the IDLE-following cycle; no dev_en during either ack cycle.
- Reset mid-access: reset=1 for one cycle during 2nd wt=1 ACCESS cycle.
  -> dev_en=0, busy=0 next cycle; no cpu_ack; a subsequent read completes normally.
- TIMEOUT=0, dev_wt=1 for 1000 cycles then 0.
  -> No abort; cpu_ack with err=0 one cycle after the first wt=0 edge.

Source files
------------

// File: rtl/bus_master.sv
// bus_master: single-initiator controller for the device bus (en/wr/addr/data/wt).
// Takes one client command at a time, drives the device lines for the access,
// stretches while the device holds wt, and reports completion with a one-cycle
// ack (plus err when the access was aborted by the wait timeout).
module bus_master #(
    parameter int ADDR_WIDTH = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic                  busy,
    output logic                  dev_en,
    output logic                  dev_wr,
    output logic [ADDR_WIDTH-1:0] dev_addr,
    output logic [31:0]           dev_data_out,
    input  logic [31:0]           dev_data_in,
    input  logic                  dev_wt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Timeout threshold as a 16-bit compare value; zero means "never abort".
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t                state_r;
    state_t                state_s;
    logic [15:0]           wait_cnt_r;
    logic [15:0]           wait_cnt_s;
    logic [15:0]           wait_inc_s;
    logic                  dev_en_s;
    logic                  dev_wr_s;
    logic [ADDR_WIDTH-1:0] dev_addr_s;
    logic [31:0]           dev_data_out_s;
    logic [31:0]           cpu_rdata_s;
    logic                  cpu_ack_s;
    logic                  cpu_err_s;
    logic                  busy_s;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_s        = state_r;
        wait_cnt_s     = wait_cnt_r;
        dev_en_s       = dev_en;
        dev_wr_s       = dev_wr;
        dev_addr_s     = dev_addr;
        dev_data_out_s = dev_data_out;
        cpu_rdata_s    = cpu_rdata;
        cpu_ack_s      = cpu_ack;
        cpu_err_s      = cpu_err;
        // The counter sticks at all-ones so a disabled timeout can never wrap.
        if (wait_cnt_r == 16'hFFFF) begin
            wait_inc_s = wait_cnt_r;
        end else begin
            wait_inc_s = wait_cnt_r + 16'd1;
        end

        case (state_r)
            ST_IDLE: begin
                dev_en_s  = 1'b0;
                dev_wr_s  = 1'b0;
                cpu_ack_s = 1'b0;
                cpu_err_s = 1'b0;
                if (cpu_req) begin
                    state_s        = ST_ACCESS;
                    dev_en_s       = 1'b1;
                    dev_wr_s       = cpu_we;
                    dev_addr_s     = cpu_addr;
                    dev_data_out_s = cpu_wdata;
                    wait_cnt_s     = 16'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!dev_wt) begin
                    // Device completes (and commits a write) on this edge.
                    cpu_rdata_s = dev_wr ? 32'd0 : dev_data_in;
                    cpu_ack_s   = 1'b1;
                    cpu_err_s   = 1'b0;
                    dev_en_s    = 1'b0;
                    dev_wr_s    = 1'b0;
                    state_s     = ST_DONE;
                end else begin
                    wait_cnt_s = wait_inc_s;
                    if ((TIMEOUT_C != 16'd0) && (wait_inc_s == TIMEOUT_C)) begin
                        cpu_rdata_s = 32'd0;
                        cpu_ack_s   = 1'b1;
                        cpu_err_s   = 1'b1;
                        dev_en_s    = 1'b0;
                        dev_wr_s    = 1'b0;
                        state_s     = ST_DONE;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end
            end
            ST_DONE: begin
                // Ack lasts exactly one cycle; requests are not looked at here.
                cpu_ack_s = 1'b0;
                cpu_err_s = 1'b0;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                dev_en_s  = 1'b0;
                dev_wr_s  = 1'b0;
                cpu_ack_s = 1'b0;
                cpu_err_s = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= 16'd0;
            dev_en       <= 1'b0;
            dev_wr       <= 1'b0;
            dev_addr     <= '0;
            dev_data_out <= 32'd0;
            cpu_rdata    <= 32'd0;
            cpu_ack      <= 1'b0;
            cpu_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_s;
            wait_cnt_r   <= wait_cnt_s;
            dev_en       <= dev_en_s;
            dev_wr       <= dev_wr_s;
            dev_addr     <= dev_addr_s;
            dev_data_out <= dev_data_out_s;
            cpu_rdata    <= cpu_rdata_s;
            cpu_ack      <= cpu_ack_s;
            cpu_err      <= cpu_err_s;
            busy         <= busy_s;
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// Testbench for bus_master: two instances share all inputs, one with TIMEOUT=8
// and one with the timeout disabled. Completions are checked against a
// scoreboard of expected {rdata, err}; cycle timing is checked inline.
module tb_bus_master;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] dev_data_in;
    logic        dev_wt;

    logic [31:0] rdata_a, dout_a, rdata_b, dout_b;
    logic        ack_a, err_a, busy_a, en_a, wr_a;
    logic        ack_b, err_b, busy_b, en_b, wr_b;
    logic [1:0]  addr_a, addr_b;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_cmp = 0;
    int n_bad = 0;

    bus_master #(.ADDR_WIDTH(2), .TIMEOUT(8)) u_dut_a (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_a),
        .cpu_ack(ack_a), .cpu_err(err_a), .busy(busy_a), .dev_en(en_a),
        .dev_wr(wr_a), .dev_addr(addr_a), .dev_data_out(dout_a),
        .dev_data_in(dev_data_in), .dev_wt(dev_wt)
    );

    bus_master #(.ADDR_WIDTH(2), .TIMEOUT(0)) u_dut_b (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_b),
        .cpu_ack(ack_b), .cpu_err(err_b), .busy(busy_b), .dev_en(en_b),
        .dev_wr(wr_b), .dev_addr(addr_b), .dev_data_out(dout_b),
        .dev_data_in(dev_data_in), .dev_wt(dev_wt)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for instance A: every ack pops one expected completion.
    always @(negedge clk) begin
        if (ack_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check_value("a_unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check_value("a_rdata", rdata_a, e.rdata);
                check_value("a_err", {31'd0, err_a}, {31'd0, e.err});
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        if (ack_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check_value("b_unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check_value("b_rdata", rdata_b, e.rdata);
                check_value("b_err", {31'd0, err_b}, {31'd0, e.err});
            end
        end
    end

    // One complete transfer with nwait wt=1 cycles; returns dev_en high count.
    task automatic do_txn(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                          input logic [31:0] din, input int nwait, output int en_cycles);
        cpu_req     = 1'b1;
        cpu_we      = we;
        cpu_addr    = addr;
        cpu_wdata   = wdata;
        dev_data_in = din;
        dev_wt      = 1'b0;
        step();
        cpu_req   = 1'b0;
        en_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            if (en_a !== 1'b1) break;
            en_cycles++;
            check_value("txn_dev_wr", {31'd0, wr_a}, {31'd0, we});
            check_value("txn_dev_addr", {30'd0, addr_a}, {30'd0, addr});
            check_value("txn_dev_dout", dout_a, wdata);
            check_value("txn_ack_low", {31'd0, ack_a}, 32'd0);
            dev_wt = (i < nwait);
            step();
        end
        dev_wt = 1'b0;
        check_value("txn_ack_high", {31'd0, ack_a}, 32'd1);
        check_value("txn_busy_done", {31'd0, busy_a}, 32'd1);
        step();
        check_value("txn_ack_gone", {31'd0, ack_a}, 32'd0);
        check_value("txn_busy_idle", {31'd0, busy_a}, 32'd0);
    endtask

    initial begin
        int ec;
        int en_a_cnt;
        reset       = 1'b1;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = 2'd0;
        cpu_wdata   = 32'd0;
        dev_data_in = 32'd0;
        dev_wt      = 1'b0;
        step();
        step();

        // Reset values
        check_value("rst_en", {31'd0, en_a}, 32'd0);
        check_value("rst_wr", {31'd0, wr_a}, 32'd0);
        check_value("rst_addr", {30'd0, addr_a}, 32'd0);
        check_value("rst_dout", dout_a, 32'd0);
        check_value("rst_rdata", rdata_a, 32'd0);
        check_value("rst_ack", {31'd0, ack_a}, 32'd0);
        check_value("rst_err", {31'd0, err_a}, 32'd0);
        check_value("rst_busy", {31'd0, busy_a}, 32'd0);
        check_value("rst_en_b", {31'd0, en_b}, 32'd0);
        reset = 1'b0;
        step();

        // Zero-wait write
        q_a.push_back('{rdata: 32'd0, err: 1'b0});
        q_b.push_back('{rdata: 32'd0, err: 1'b0});
        do_txn(1'b1, 2'd1, 32'h0000C350, 32'hDEADBEEF, 0, ec);
        check_value("wr_en_cycles", ec, 32'd1);

        // Read with three wait cycles
        q_a.push_back('{rdata: 32'h00000003, err: 1'b0});
        q_b.push_back('{rdata: 32'h00000003, err: 1'b0});
        do_txn(1'b0, 2'd0, 32'h12345678, 32'h00000003, 3, ec);
        check_value("rd_en_cycles", ec, 32'd4);

        // Back-to-back: write then read with cpu_req held high
        q_a.push_back('{rdata: 32'd0, err: 1'b0});
        q_b.push_back('{rdata: 32'd0, err: 1'b0});
        q_a.push_back('{rdata: 32'hCAFE0002, err: 1'b0});
        q_b.push_back('{rdata: 32'hCAFE0002, err: 1'b0});
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 2'd3;
        cpu_wdata = 32'h0BADF00D;
        step();
        check_value("b2b_en1", {31'd0, en_a}, 32'd1);
        check_value("b2b_wr1", {31'd0, wr_a}, 32'd1);
        cpu_we      = 1'b0;
        cpu_addr    = 2'd2;
        dev_data_in = 32'hCAFE0002;
        step();
        check_value("b2b_ack1", {31'd0, ack_a}, 32'd1);
        check_value("b2b_en_in_ack1", {31'd0, en_a}, 32'd0);
        step();
        check_value("b2b_idle_ack", {31'd0, ack_a}, 32'd0);
        check_value("b2b_idle_en", {31'd0, en_a}, 32'd0);
        step();
        check_value("b2b_en2", {31'd0, en_a}, 32'd1);
        check_value("b2b_wr2", {31'd0, wr_a}, 32'd0);
        check_value("b2b_addr2", {30'd0, addr_a}, 32'd2);
        cpu_req = 1'b0;
        step();
        check_value("b2b_ack2", {31'd0, ack_a}, 32'd1);
        check_value("b2b_en_in_ack2", {31'd0, en_a}, 32'd0);
        step();

        // Reset during the second wt=1 access cycle kills the transfer silently
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = 2'd1;
        dev_data_in = 32'h55AA55AA;
        step();
        cpu_req = 1'b0;
        dev_wt  = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset  = 1'b0;
        dev_wt = 1'b0;
        check_value("rstmid_en", {31'd0, en_a}, 32'd0);
        check_value("rstmid_busy", {31'd0, busy_a}, 32'd0);
        check_value("rstmid_ack", {31'd0, ack_a}, 32'd0);
        check_value("rstmid_en_b", {31'd0, en_b}, 32'd0);
        step();
        check_value("rstmid_ack_later", {31'd0, ack_a}, 32'd0);
        q_a.push_back('{rdata: 32'h00000077, err: 1'b0});
        q_b.push_back('{rdata: 32'h00000077, err: 1'b0});
        do_txn(1'b0, 2'd1, 32'd0, 32'h00000077, 1, ec);
        check_value("rstmid_rd_en_cycles", ec, 32'd2);

        // Stuck wt: A aborts after 8 cycles, B waits 1000 cycles then completes
        q_a.push_back('{rdata: 32'd0, err: 1'b1});
        q_b.push_back('{rdata: 32'hA5A50003, err: 1'b0});
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = 2'd3;
        dev_data_in = 32'hA5A50003;
        step();
        cpu_req  = 1'b0;
        dev_wt   = 1'b1;
        en_a_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (en_a === 1'b1) en_a_cnt++;
            if (i == 8) begin
                check_value("to_ack", {31'd0, ack_a}, 32'd1);
                check_value("to_err", {31'd0, err_a}, 32'd1);
                check_value("to_busy_done", {31'd0, busy_a}, 32'd1);
            end
            if (i == 9) begin
                check_value("to_busy_fall", {31'd0, busy_a}, 32'd0);
                check_value("to_ack_gone", {31'd0, ack_a}, 32'd0);
            end
            if (i % 100 == 50) begin
                check_value("noto_en_b", {31'd0, en_b}, 32'd1);
            end
            step();
        end
        check_value("to_en_cycles", en_a_cnt, 32'd8);
        check_value("noto_still_en", {31'd0, en_b}, 32'd1);
        check_value("noto_no_ack", {31'd0, ack_b}, 32'd0);
        dev_wt = 1'b0;
        step();
        check_value("noto_ack", {31'd0, ack_b}, 32'd1);
        check_value("noto_en_off", {31'd0, en_b}, 32'd0);
        step();
        step();
        @(negedge clk);

        check_value("q_a_left", q_a.size(), 32'd0);
        check_value("q_b_left", q_b.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
